// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with relative branch, circular return-address stack and sticky stack-error flags
module pc_unit #(
    parameter int ADDR_W = 27,
    parameter int OFF_W = 16,
    parameter int RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_addr_in,
    input  logic              br_take,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic              call,
    input  logic              ret,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    assign pc_out        = pc_q;
    assign ras_empty     = cnt_q == '0;
    assign ras_full      = cnt_q == CNT_W'(RAS_DEPTH);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    // Single prioritised action per cycle; a flag set in the same cycle beats err_clr
    always_comb begin
        push  = 1'b0;
        pc_d  = pc_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~err_clr;
        unf_d = unf_q & ~err_clr;
        if (stall) begin
            ovf_d = ovf_q;
            unf_d = unf_q;
        end else if (ret) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                pc_d  = ras_q[wp_q - PTR_W'(1)];
                wp_d  = wp_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (call) begin
            push  = 1'b1;
            pc_d  = pc_addr_in;
            wp_d  = wp_q + PTR_W'(1);
            ovf_d = ras_full | ovf_d;
            cnt_d = ras_full ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pc_load) begin
            pc_d = pc_addr_in;
        end else if (br_take) begin
            pc_d = pc_q + ADDR_W'($signed(br_offset));
        end else if (pc_inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC, stack pointers and flags with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= RESET_ADDR;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage; on a full stack the write wraps onto the oldest entry
    always_ff @(posedge clock) begin
        if (push)
            ras_q[wp_q] <= pc_q + ADDR_W'(1);
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: vector table, overflow sequence and randomized run against a queue-based reference model
module tb_pc_unit;
    localparam int AW = 27;
    localparam int DEPTH = 8;
    localparam logic [7:0] R = 8'h80, S = 8'h40, RT = 8'h20, C = 8'h10,
                           L = 8'h08, B = 8'h04, I = 8'h02, CL = 8'h01;

    typedef struct packed {
        logic [7:0]    ctl;
        logic [AW-1:0] addr;
        logic [15:0]   off;
        logic [AW-1:0] pc;
        logic [3:0]    flg;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset, stall, pc_inc, pc_load, br_take, call, ret, err_clr;
    logic [AW-1:0] pc_addr_in;
    logic [15:0]   br_offset;
    logic [AW-1:0] pc_out;
    logic          ras_empty, ras_full, ras_overflow, ras_underflow;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ras [$];
    logic          m_ovf, m_unf;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .pc_inc(pc_inc),
        .pc_load(pc_load), .pc_addr_in(pc_addr_in), .br_take(br_take),
        .br_offset(br_offset), .call(call), .ret(ret), .err_clr(err_clr),
        .pc_out(pc_out), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    function automatic vec_t v(input logic [7:0] c, input logic [AW-1:0] a, input logic [15:0] o,
                               input logic [AW-1:0] p, input logic [3:0] f);
        return '{ctl: c, addr: a, off: o, pc: p, flg: f};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic model(input logic [7:0] c, input logic [AW-1:0] a, input logic [15:0] o);
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        if (c[7]) begin
            m_pc = '0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!c[6]) begin
            if (c[5]) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else su = 1'b1;
            end else if (c[4]) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    so = 1'b1;
                end
                m_ras.push_back(m_pc + 1'b1);
                m_pc = a;
            end else if (c[3]) m_pc = a;
            else if (c[2]) m_pc = AW'(int'(m_pc) + int'($signed(o)));
            else if (c[1]) m_pc = m_pc + 1'b1;
            m_ovf = so | (m_ovf & ~c[0]);
            m_unf = su | (m_unf & ~c[0]);
        end
    endtask

    task automatic apply(input logic [7:0] c, input logic [AW-1:0] a, input logic [15:0] o);
        {reset, stall, ret, call, pc_load, br_take, pc_inc, err_clr} = c;
        pc_addr_in = a;
        br_offset = o;
        model(c, a, o);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string n, input logic [AW-1:0] p, input logic [3:0] f);
        chk({n, ".pc"}, 32'(pc_out), 32'(p));
        chk({n, ".empty"}, 32'(ras_empty), 32'(f[3]));
        chk({n, ".full"}, 32'(ras_full), 32'(f[2]));
        chk({n, ".ovf"}, 32'(ras_overflow), 32'(f[1]));
        chk({n, ".unf"}, 32'(ras_underflow), 32'(f[0]));
    endtask

    initial begin
        vec_t tbl [$];
        logic [AW-1:0] p [9];
        logic [AW-1:0] t;
        tbl.push_back(v(R,        0,        0,        27'h0,       4'b1000));
        tbl.push_back(v(I,        0,        0,        27'h1,       4'b1000));
        tbl.push_back(v(I,        0,        0,        27'h2,       4'b1000));
        tbl.push_back(v(I,        0,        0,        27'h3,       4'b1000));
        tbl.push_back(v(L,        27'h7FFFFFF, 0,     27'h7FFFFFF, 4'b1000));
        tbl.push_back(v(I,        0,        0,        27'h0,       4'b1000));
        tbl.push_back(v(L,        27'h10,   0,        27'h10,      4'b1000));
        tbl.push_back(v(B,        0,        16'hFFE0, 27'h7FFFFF0, 4'b1000));
        tbl.push_back(v(B,        0,        16'h7FFF, 27'h0007FEF, 4'b1000));
        tbl.push_back(v(L,        27'h100,  0,        27'h100,     4'b1000));
        tbl.push_back(v(C,        27'h400,  0,        27'h400,     4'b0000));
        tbl.push_back(v(C,        27'h800,  0,        27'h800,     4'b0000));
        tbl.push_back(v(RT,       0,        0,        27'h401,     4'b0000));
        tbl.push_back(v(RT,       0,        0,        27'h101,     4'b1000));
        tbl.push_back(v(RT,       0,        0,        27'h101,     4'b1001));
        tbl.push_back(v(CL,       0,        0,        27'h101,     4'b1000));
        tbl.push_back(v(S|C|I,    27'h555,  0,        27'h101,     4'b1000));
        tbl.push_back(v(C,        27'h300,  0,        27'h300,     4'b0000));
        tbl.push_back(v(RT|C|L,   27'h999,  0,        27'h102,     4'b1000));
        tbl.push_back(v(C,        27'h200,  0,        27'h200,     4'b0000));
        tbl.push_back(v(C,        27'h240,  0,        27'h240,     4'b0000));
        tbl.push_back(v(R|S,      0,        0,        27'h0,       4'b1000));
        tbl.push_back(v(RT,       0,        0,        27'h0,       4'b1001));
        tbl.push_back(v(S|CL,     0,        0,        27'h0,       4'b1001));
        tbl.push_back(v(RT|CL,    0,        0,        27'h0,       4'b1001));
        tbl.push_back(v(CL,       0,        0,        27'h0,       4'b1000));
        foreach (tbl[k]) begin
            apply(tbl[k].ctl, tbl[k].addr, tbl[k].off);
            chk_all($sformatf("vec%0d", k), tbl[k].pc, tbl[k].flg);
        end

        apply(R, 0, 0);
        apply(L, 27'h1000, 0);
        for (int i = 0; i < 9; i++) begin
            t = AW'(32'h2000 + i * 16);
            p[i] = (i == 0) ? 27'h1001 : AW'(32'h2000 + (i - 1) * 16 + 1);
            apply(C, t, 0);
            if (i == 7) chk_all("ovf.call8", t, 4'b0100);
        end
        chk_all("ovf.call9", AW'(32'h2080), 4'b0110);
        for (int k = 0; k < 8; k++) begin
            apply(RT, 0, 0);
            chk_all($sformatf("ovf.ret%0d", k), p[8 - k], k == 7 ? 4'b1010 : 4'b0010);
        end
        apply(RT, 0, 0);
        chk_all("ovf.ret9", p[1], 4'b1011);
        for (int k = 0; k < 5; k++) apply(S | RT | R >> 1, 0, 0);
        chk_all("ovf.stallhold", p[1], 4'b1011);
        apply(CL, 0, 0);
        chk_all("ovf.clr", p[1], 4'b1000);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            c[7] = $urandom_range(0, 99) < 2;
            c[6] = $urandom_range(0, 99) < 15;
            c[5] = $urandom_range(0, 99) < 25;
            c[4] = $urandom_range(0, 99) < 30;
            c[3] = $urandom_range(0, 99) < 15;
            c[2] = $urandom_range(0, 99) < 25;
            c[1] = $urandom_range(0, 99) < 50;
            c[0] = $urandom_range(0, 99) < 10;
            apply(c, AW'($urandom), 16'($urandom));
            chk_all("rand", m_pc, {m_ras.size() == 0, m_ras.size() == DEPTH, m_ovf, m_unf});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the core fetch stage, and the successor to the fixed 27-bit load/increment counter. It adds PC-relative branches, a circular return-address stack (RAS) for call/return, a fetch stall, and sticky stack-error flags. Redirect requests come from the decode/control unit. `pc_out` drives the instruction-memory address.

## Interface
Parameters:
- `ADDR_W`, 27: PC width in bits (word address).
- `OFF_W`, 16: width of the signed branch offset; must be ≤ `ADDR_W`.
- `RAS_DEPTH`, 8: return-stack entries; power of two, ≥ 2.
- `RESET_ADDR`, 0: value loaded into the PC on reset.

Ports:
- `clock`, in, 1: single clock. All state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high. Returns every register to its reset value.
- `stall`, in, 1: freeze the PC and the RAS; all requests this cycle are ignored.
- `pc_inc`, in, 1: advance the PC by 1.
- `pc_load`, in, 1: absolute jump to `pc_addr_in`.
- `pc_addr_in`, in, `ADDR_W`: jump or call target.
- `br_take`, in, 1: relative branch by `br_offset`.
- `br_offset`, in, `OFF_W`: signed two's-complement offset, relative to the current `pc_out`.
- `call`, in, 1: push `pc_out+1` onto the RAS and jump to `pc_addr_in`.
- `ret`, in, 1: pop the RAS and jump to the popped address.
- `err_clr`, in, 1: clear both sticky error flags.
- `pc_out`, out, `ADDR_W`: current PC (registered).
- `ras_empty`, out, 1: RAS holds no valid entries (registered).
- `ras_full`, out, 1: RAS holds `RAS_DEPTH` entries (registered).
- `ras_overflow`, out, 1: sticky; a push occurred while the RAS was full.
- `ras_underflow`, out, 1: sticky; a pop occurred while the RAS was empty.

## Operation
- State:
  - PC register.
  - RAS array of `RAS_DEPTH` × `ADDR_W`.
  - Write pointer `wp`, `log2(RAS_DEPTH)` bits; wraps modulo the depth.
  - Occupancy counter `cnt`, 0..`RAS_DEPTH`, saturating.
  - Two sticky flags.
- Priority, evaluated once per cycle, highest first. Exactly one action executes; lower-priority requests in the same cycle are dropped.
  1. `reset`: PC = `RESET_ADDR`, `wp` = 0, `cnt` = 0, flags = 0. RAS array contents are don't-care.
  2. `stall`: no state changes, including the flags and `err_clr`.
  3. `ret`:
     - If `cnt` > 0: PC = `ras[wp-1]`, `wp` decrements, `cnt` decrements.
     - If `cnt` = 0: PC holds, `ras_underflow` is set, pointers are unchanged.
  4. `call`:
     - `ras[wp]` = `pc_out+1` (mod 2^`ADDR_W`), `wp` increments, PC = `pc_addr_in`.
     - If `cnt` < `RAS_DEPTH`: `cnt` increments.
     - Else: the oldest entry is overwritten, `cnt` stays at `RAS_DEPTH`, and `ras_overflow` is set.
  5. `pc_load`: PC = `pc_addr_in`.
  6. `br_take`: PC = `pc_out` + sign-extended `br_offset`, truncated to `ADDR_W` bits (wraps modulo 2^`ADDR_W`).
  7. `pc_inc`: PC = `pc_out+1`; wraps from all-ones to 0.
  8. No request: PC holds.
- `err_clr` (when not stalled and not in reset) clears both flags. A set condition in the same cycle wins over the clear.
- `ras_empty` = (`cnt` == 0); `ras_full` = (`cnt` == `RAS_DEPTH`). Both derive from registered `cnt`.
- After an overflow, a pop returns the newest entries. Once `RAS_DEPTH` pops have been made, `cnt` reaches 0 and the next pop underflows; the lost entries are never returned.

## Timing
- Reset values: `pc_out` = `RESET_ADDR`, `ras_empty` = 1, `ras_full` = 0, `ras_overflow` = 0, `ras_underflow` = 0.
- Latency is 1 cycle: a request sampled at edge N is visible on `pc_out` and the flags after edge N. There is no combinational path from any input to any output.
- Back-to-back `call`/`ret` are allowed every cycle. A `ret` in the cycle immediately after a `call` returns that call's pushed address.
- `reset` asserted mid-sequence, including while `stall` is high, takes effect at the next edge; the RAS is empty afterwards.
- `stall` held for any number of cycles preserves all state exactly.

## Test plan
- Reset, then 3 cycles of `pc_inc` → `pc_out` = 0, 1, 2, 3; `ras_empty` = 1.
- `ADDR_W` = 27, PC = 0x7FFFFFF, `pc_inc` → PC = 0. PC = 0x10, `br_take` with `br_offset` = -0x20 → PC = 0x7FFFFF0.
- PC = 0x100, `call` to 0x400 → PC = 0x400. Then `call` to 0x800 → PC = 0x800. Then `ret` → PC = 0x401. Then `ret` → PC = 0x101; `ras_empty` = 1.
- `RAS_DEPTH` = 8: perform 9 calls → `ras_overflow` = 1 and `ras_full` = 1. Then 8 rets return the last 8 pushed addresses, newest first. A 9th ret → PC holds and `ras_underflow` = 1. `err_clr` → both flags 0.
- `stall` together with `call` + `pc_inc` → nothing changes. Deassert `stall`, assert `ret` + `call` + `pc_load` together → only the `ret` executes.
- Mid-stack, assert `reset` while `stall` = 1 → next cycle PC = `RESET_ADDR`, `ras_empty` = 1, flags = 0.
